codificador_selecao: RTL and testbench

- Converts four active-high selection lines (user buttons, one per drink) into a registered 2-bit code with a valid/accept handshake. It performs the inverse of the 2-bit-to-one-hot decode used for display scanning.
- Inputs are synchronised, debounced and priority-encoded. One press produces exactly one code transfer toward the controller FSM.

---
 rtl/codificador_pkg.sv | 32 +++
 rtl/debouncer_entrada.sv | 35 +++
 rtl/codificador_selecao.sv | 91 +++++++++
 tb/tb_codificador_selecao.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/codificador_pkg.sv
// Shared constants, FSM state type and encoding helpers for codificador_selecao.
package codificador_pkg;

  localparam int unsigned NUM_ENTRADAS = 4;
  localparam int unsigned CODIGO_W     = 2;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    AGUARDA = 2'd1,
    SOLTA   = 2'd2
  } estado_t;

  // Lowest set index wins; returns 0 for an all-zero vector.
  function automatic logic [CODIGO_W-1:0] prioridade(input logic [NUM_ENTRADAS-1:0] v);
    logic [CODIGO_W-1:0] p;
    logic                achou;
    p     = '0;
    achou = 1'b0;
    for (int unsigned i = 0; i < NUM_ENTRADAS; i++) begin
      if (v[i] && !achou) begin
        p     = CODIGO_W'(i);
        achou = 1'b1;
      end
    end
    return p;
  endfunction

  function automatic logic multiplo(input logic [NUM_ENTRADAS-1:0] v);
    return |(v & (v - NUM_ENTRADAS'(1)));
  endfunction

endpackage

// File: rtl/debouncer_entrada.sv
// One selection line: 2-flop synchroniser, debounce counter and debounced level flop.
module debouncer_entrada #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic entrada,
  output logic estavel
);

  localparam logic [CNT_W-1:0] LIMITE = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= '0;
      cnt     <= '0;
      estavel <= 1'b0;
    end else begin
      sync <= {sync[0], entrada};
      if (sync[1] == estavel) begin
        cnt <= '0;
      end else if (cnt == LIMITE) begin
        estavel <= ~estavel;
        cnt     <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/codificador_selecao.sv
// Debounced 4-line priority encoder with valid/accept handshake.
// Optional macro MULTI_PRESS_ERR_EN rejects simultaneous presses and pulses erro.
module codificador_selecao
  import codificador_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [NUM_ENTRADAS-1:0] entradas,
  input  logic                    aceito,
  output logic [CODIGO_W-1:0]     codigo,
  output logic                    valido,
  output logic [NUM_ENTRADAS-1:0] estavel,
  output logic                    erro
);

  estado_t                 estado, estado_prox;
  logic [CODIGO_W-1:0]     codigo_prox;
  logic [NUM_ENTRADAS-1:0] estavel_ant;
  logic [NUM_ENTRADAS-1:0] press;
  logic                    erro_prox;

  for (genvar gi = 0; gi < NUM_ENTRADAS; gi++) begin : g_deb
    debouncer_entrada #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk    (CLK),
      .rst_n  (RESET_N),
      .entrada(entradas[gi]),
      .estavel(estavel[gi])
    );
  end

  assign press  = estavel & ~estavel_ant;
  assign valido = (estado == AGUARDA);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      estado      <= OCIOSO;
      codigo      <= '0;
      estavel_ant <= '0;
    end else begin
      estado      <= estado_prox;
      codigo      <= codigo_prox;
      estavel_ant <= estavel;
    end
  end

  always_comb begin
    estado_prox = estado;
    codigo_prox = codigo;
    erro_prox   = 1'b0;
    case (estado)
      OCIOSO: begin
        if (|press) begin
`ifdef MULTI_PRESS_ERR_EN
          if (multiplo(press) || multiplo(estavel)) begin
            erro_prox   = 1'b1;
            estado_prox = SOLTA;
          end else begin
            codigo_prox = prioridade(press);
            estado_prox = AGUARDA;
          end
`else
          codigo_prox = prioridade(press);
          estado_prox = AGUARDA;
`endif
        end
      end
      AGUARDA: if (aceito) estado_prox = SOLTA;
      SOLTA:   if (estavel == '0) estado_prox = OCIOSO;
      default: estado_prox = OCIOSO;
    endcase
  end

`ifdef MULTI_PRESS_ERR_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) erro <= 1'b0;
    else          erro <= erro_prox;
  end
`else
  // erro_prox is only consumed when the multi-press check is built in.
  logic erro_nao_usado;
  assign erro_nao_usado = erro_prox;
  assign erro           = 1'b0;
`endif

endmodule

// File: tb/tb_codificador_selecao.sv
// Randomised + directed bench for codificador_selecao against a behavioural model.
module tb_codificador_selecao;

  localparam int unsigned DC = 4;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b1;
  logic [3:0] entradas = 4'b0;
  logic       aceito = 1'b0;
  logic [1:0] codigo;
  logic       valido;
  logic [3:0] estavel;
  logic       erro;

  codificador_selecao #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (16)
  ) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .entradas(entradas),
    .aceito  (aceito),
    .codigo  (codigo),
    .valido  (valido),
    .estavel (estavel),
    .erro    (erro)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nome, act, exp, $time);
    end
  endtask

  // Behavioural model: a level is accepted after DC consecutive differing synced
  // samples; a newly accepted high is a press; one transfer per press, then wait for all-released.
  logic [3:0] m_s1, m_s2, m_est, m_prev;
  int         m_run [4];
  logic       m_pend, m_solta, m_err;
  int         m_code;

  function automatic int ones(input logic [3:0] v);
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge CLK or negedge RESET_N) begin : modelo
    logic [3:0] pr, est_old;
    if (!RESET_N) begin
      m_s1 = '0; m_s2 = '0; m_est = '0; m_prev = '0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_pend = 0; m_solta = 0; m_err = 0; m_code = 0;
    end else begin
      est_old = m_est;
      pr      = m_est & ~m_prev;
      m_prev  = m_est;
      for (int i = 0; i < 4; i++) begin
        if (m_s2[i] != m_est[i]) begin
          m_run[i]++;
          if (m_run[i] == DC) begin
            m_est[i] = ~m_est[i];
            m_run[i] = 0;
          end
        end else m_run[i] = 0;
      end
      m_s2 = m_s1;
      m_s1 = entradas;
      m_err = 0;
      if (m_pend) begin
        if (aceito) begin m_pend = 0; m_solta = 1; end
      end else if (m_solta) begin
        if (est_old == 0) m_solta = 0;
      end else if (pr != 0) begin
`ifdef MULTI_PRESS_ERR_EN
        if (ones(pr) > 1 || ones(est_old) > 1) begin
          m_err = 1; m_solta = 1;
        end else begin
          m_code = lowest(pr); m_pend = 1;
        end
`else
        m_code = lowest(pr); m_pend = 1;
`endif
      end
    end
  end

  always @(negedge CLK) begin
    if (RESET_N) begin
      chk("estavel", 32'(estavel), 32'(m_est));
      chk("valido", 32'(valido), 32'(m_pend));
      if (m_pend) chk("codigo", 32'(codigo), 32'(m_code));
      chk("erro", 32'(erro), 32'(m_err));
    end
  end

  task automatic ciclos(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_valido(input int max, output int n);
    n = 0;
    while (!valido && n < max) begin
      @(negedge CLK);
      n++;
    end
  endtask

  task automatic aceita();
    aceito = 1'b1;
    @(negedge CLK);
    aceito = 1'b0;
  endtask

  int n, cv, ce, c1;
  logic [1:0] cod_visto;

  initial begin
    #1 RESET_N = 1'b0;
    #1;
    chk("reset_valido", 32'(valido), 0);
    chk("reset_estavel", 32'(estavel), 0);
    ciclos(2);
    RESET_N = 1'b1;
    ciclos(3);

    // Single press on line 2: valido exactly DC+3 clocks later
    entradas = 4'b0100;
    wait_valido(30, n);
    chk("latencia", n, DC + 3);
    chk("cod_sel2", 32'(codigo), 2);
    chk("modelo_cod2", m_code, 2);
    ciclos(10);
    chk("segura_valido", 32'(valido), 1);
    chk("segura_codigo", 32'(codigo), 2);
    aceita();
    chk("aceito_valido", 32'(valido), 0);
    entradas = 4'b0;
    ciclos(12);

    // Reset while a code for line 2 is pending
    entradas = 4'b0100;
    wait_valido(30, n);
    chk("pre_reset_cod", 32'(codigo), 2);
    @(posedge CLK);
    #2 RESET_N = 1'b0;
    entradas = 4'b0;
    #1;
    chk("rst_valido", 32'(valido), 0);
    chk("rst_codigo", 32'(codigo), 0);
    chk("rst_estavel", 32'(estavel), 0);
    chk("rst_erro", 32'(erro), 0);
    @(negedge CLK);
    RESET_N = 1'b1;
    cv = 0;
    repeat (20) begin @(negedge CLK); cv += int'(valido); end
    chk("pos_reset_quieto", cv, 0);

    // Bounce: highs shorter than the debounce window
    cv = 0; c1 = 0;
    repeat (4) begin
      entradas = 4'b0010;
      repeat (3) begin @(negedge CLK); cv += int'(valido); c1 += int'(estavel[1]); end
      entradas = 4'b0000;
      repeat (3) begin @(negedge CLK); cv += int'(valido); c1 += int'(estavel[1]); end
    end
    repeat (6) begin @(negedge CLK); cv += int'(valido); c1 += int'(estavel[1]); end
    chk("bounce_valido", cv, 0);
    chk("bounce_estavel1", c1, 0);
    entradas = 4'b0010;
    wait_valido(30, n);
    chk("bounce_lat", n, DC + 3);
    chk("bounce_cod", 32'(codigo), 1);
    aceita();
    entradas = 4'b0;
    ciclos(12);

    // Simultaneous press on lines 1 and 3
    entradas = 4'b1010;
    cv = 0; ce = 0; cod_visto = 2'd3;
    repeat (16) begin
      @(negedge CLK);
      if (valido && cv == 0) cod_visto = codigo;
      cv += int'(valido);
      ce += int'(erro);
    end
`ifdef MULTI_PRESS_ERR_EN
    chk("multi_valido", cv, 0);
    chk("multi_erro", ce, 1);
`else
    chk("multi_cod", 32'(cod_visto), 1);
    chk("multi_erro", ce, 0);
`endif
    if (valido) aceita();
    entradas = 4'b0;
    ciclos(12);

    // No repeat with aceito tied high
    aceito = 1'b1;
    entradas = 4'b1000;
    cv = 0;
    repeat (40) begin @(negedge CLK); cv += int'(valido); end
    chk("sem_repeticao", cv, 1);
    entradas = 4'b0;
    ciclos(12);
    aceito = 1'b0;

    // No queue: press line 0 while line 3 is pending
    entradas = 4'b1000;
    wait_valido(30, n);
    chk("fila_cod3", 32'(codigo), 3);
    entradas = 4'b1001;
    ciclos(15);
    chk("fila_valido", 32'(valido), 1);
    chk("fila_codigo", 32'(codigo), 3);
    aceita();
    cv = 0;
    repeat (20) begin @(negedge CLK); cv += int'(valido); end
    chk("fila_ignorada", cv, 0);
    entradas = 4'b0;
    ciclos(12);
    entradas = 4'b0001;
    wait_valido(30, n);
    chk("fila_cod0", 32'(codigo), 0);
    aceita();
    entradas = 4'b0;
    ciclos(12);

    // Random stimulus checked by the model every cycle
    for (int s = 0; s < 250; s++) begin
      entradas = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) entradas = 4'b0;
      repeat ($urandom_range(1, 12)) begin
        aceito = ($urandom_range(0, 3) == 0);
        @(negedge CLK);
      end
    end
    aceito = 1'b0;
    entradas = 4'b0;
    ciclos(12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
